// File: rtl/bcd_tens_display.sv
// bcd_tens_display
//   Extends a mod-10 BCD count into a two-digit 00-99 value by counting decade
//   roll-overs (9 -> 0) in a tens digit. It drives a two-digit time-multiplexed
//   seven-segment display and flags non-BCD input and tens overflow.
//
// Parameters
//   REFRESH_DIV  cycles each digit stays enabled before the mux switches (2-255)
//
// Ports
//   i_clk       system clock, all logic on posedge
//   i_rst       synchronous active-low reset
//   i_ones_in   BCD count from the upstream mod-10 counter
//   o_ones_q    registered copy of i_ones_in
//   o_tens_q    tens digit, BCD 0-9
//   o_rollover  one-cycle pulse on each decade increment
//   o_overflow  sticky, set when tens wraps 9 -> 0
//   o_bcd_err   one-cycle pulse, i_ones_in was > 9 on the previous edge
//   o_seg       {g,f,e,d,c,b,a}, active-high segments
//   o_an        active-low digit enables, [0] = ones, [1] = tens
module bcd_tens_display #(
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_ones_in,
  output logic [3:0] o_ones_q,
  output logic [3:0] o_tens_q,
  output logic       o_rollover,
  output logic       o_overflow,
  output logic       o_bcd_err,
  output logic [6:0] o_seg,
  output logic [1:0] o_an
);

  localparam logic [7:0] LastCnt = 8'(REFRESH_DIV - 1);

  logic [3:0] r_ones;
  logic [3:0] r_tens;
  logic       r_rollover;
  logic       r_overflow;
  logic       r_bcd_err;
  logic [6:0] r_seg;
  logic [1:0] r_an;
  logic       r_seen;
  logic       r_sel;
  logic [7:0] r_refresh_cnt;

  logic       w_wrap;
  logic       w_tens_max;
  logic       w_cnt_last;
  logic [3:0] w_digit;
  logic [6:0] w_seg_enc;

  always_comb begin
    // r_seen masks the reset value of r_ones so the first sample can't look like 9 -> 0.
    w_wrap     = r_seen && (r_ones == 4'd9) && (i_ones_in == 4'd0);
    w_tens_max = (r_tens == 4'd9);
    w_cnt_last = (r_refresh_cnt == LastCnt);
    w_digit    = r_sel ? r_tens : r_ones;
  end

  // Non-BCD codes blank the digit.
  always_comb begin
    w_seg_enc = 7'h00;
    case (w_digit)
      4'd0:    w_seg_enc = 7'h3F;
      4'd1:    w_seg_enc = 7'h06;
      4'd2:    w_seg_enc = 7'h5B;
      4'd3:    w_seg_enc = 7'h4F;
      4'd4:    w_seg_enc = 7'h66;
      4'd5:    w_seg_enc = 7'h6D;
      4'd6:    w_seg_enc = 7'h7D;
      4'd7:    w_seg_enc = 7'h07;
      4'd8:    w_seg_enc = 7'h7F;
      4'd9:    w_seg_enc = 7'h6F;
      default: w_seg_enc = 7'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ones        <= 4'd0;
      r_tens        <= 4'd0;
      r_rollover    <= 1'b0;
      r_overflow    <= 1'b0;
      r_bcd_err     <= 1'b0;
      r_seg         <= 7'h00;
      r_an          <= 2'b11;
      r_seen        <= 1'b0;
      r_sel         <= 1'b0;
      r_refresh_cnt <= 8'd0;
    end else begin
      r_ones     <= i_ones_in;
      r_seen     <= 1'b1;
      r_bcd_err  <= (i_ones_in > 4'd9);
      r_rollover <= w_wrap;

      if (w_wrap) begin
        if (w_tens_max) begin
          r_tens     <= 4'd0;
          r_overflow <= 1'b1;
        end else begin
          r_tens <= r_tens + 4'd1;
        end
      end

      if (w_cnt_last) begin
        r_refresh_cnt <= 8'd0;
        r_sel         <= ~r_sel;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + 8'd1;
      end

      // Display registers use the pre-edge sel and digits, so they lag by one cycle.
      r_an  <= r_sel ? 2'b01 : 2'b10;
      r_seg <= w_seg_enc;
    end
  end

  assign o_ones_q   = r_ones;
  assign o_tens_q   = r_tens;
  assign o_rollover = r_rollover;
  assign o_overflow = r_overflow;
  assign o_bcd_err  = r_bcd_err;
  assign o_seg      = r_seg;
  assign o_an       = r_an;

endmodule
